// File: rtl/regfile_hilo_pkg.sv
// ---------------------------------------------------------------------------
// regfile_hilo_pkg
// Shared definitions for the register file: bus/address types, register
// count, canonical zero values and enable/reset polarities.
// ---------------------------------------------------------------------------
package regfile_hilo_pkg;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegWidth   = 32;

  typedef logic [RegWidth-1:0]   RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr = 5'd0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

endpackage : regfile_hilo_pkg

// File: rtl/regfile_hilo_if.sv
// ---------------------------------------------------------------------------
// regfile_hilo_if
// Bundles the write-back and decode-side signals of the register file.
//   master : WB/ID side   - drives write/read requests and HI/LO write data
//   slave  : register file - returns read data and current HI/LO
// ---------------------------------------------------------------------------
interface regfile_hilo_if
  import regfile_hilo_pkg::*;
#(
  parameter int REG_WIDTH  = RegWidth,
  parameter int ADDR_WIDTH = RegNumLog2
);

  // GPR write port (from WB)
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [REG_WIDTH-1:0]  wdata;

  // Read port 1 (from decode)
  logic                  re1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [REG_WIDTH-1:0]  rdata1;

  // Read port 2 (from decode)
  logic                  re2;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [REG_WIDTH-1:0]  rdata2;

  // HI/LO pair
  logic                  whilo;
  logic [REG_WIDTH-1:0]  hi_i;
  logic [REG_WIDTH-1:0]  lo_i;
  logic [REG_WIDTH-1:0]  hi_o;
  logic [REG_WIDTH-1:0]  lo_o;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1,
    output re2, raddr2,
    output whilo, hi_i, lo_i,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1,
    input  re2, raddr2,
    input  whilo, hi_i, lo_i,
    output rdata1, rdata2, hi_o, lo_o
  );

endinterface : regfile_hilo_if

// File: rtl/regfile_hilo_hilo_reg.sv
// ---------------------------------------------------------------------------
// hilo_reg
// HI/LO register pair. Both halves are written together when whilo is set;
// outputs are the registered values (one-cycle write latency, no bypass).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   whilo        : HI/LO write enable
//   hi_i, lo_i   : HI/LO write data
//   hi_o, lo_o   : current HI/LO
// ---------------------------------------------------------------------------
module hilo_reg
  import regfile_hilo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  whilo,
  input  RegBus hi_i,
  input  RegBus lo_i,
  output RegBus hi_o,
  output RegBus lo_o
);

  RegBus hi;
  RegBus lo;

  // HI/LO state: cleared by reset, loaded as a pair on whilo
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (whilo == WriteEnable) begin
      hi <= hi_i;
      lo <= lo_i;
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule : hilo_reg

// File: rtl/regfile_hilo.sv
// ---------------------------------------------------------------------------
// regfile_hilo
// 32-entry general-purpose register file plus HI/LO pair.
//   - two combinational read ports with write-through bypass from WB
//   - one synchronous GPR write port (writes to register 0 are dropped)
//   - one synchronous HI/LO write port (hilo_reg sub-module)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; forces all read data to zero
//   bus  : regfile_hilo_if.slave (write port, two read ports, HI/LO)
// ---------------------------------------------------------------------------
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int REG_NUM    = RegNum,
  parameter int REG_WIDTH  = RegWidth,
  parameter int ADDR_WIDTH = RegNumLog2
)(
  input  logic           clk,
  input  logic           rst,
  regfile_hilo_if.slave  bus
);

  logic [REG_WIDTH-1:0] regs [REG_NUM];
  logic [REG_WIDTH-1:0] rdata1;
  logic [REG_WIDTH-1:0] rdata2;

  // GPR array: async clear, synchronous write; register 0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= {REG_WIDTH{1'b0}};
      end
    end else if ((bus.we == WriteEnable) && (bus.waddr != NOPRegAddr)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Read port 1: reset and register 0 dominate the bypass, so a dropped
  // write to register 0 can never leak through as read data
  always_comb begin
    rdata1 = {REG_WIDTH{1'b0}};
    if (rst == RstEnable) begin
      rdata1 = {REG_WIDTH{1'b0}};
    end else if (bus.raddr1 == NOPRegAddr) begin
      rdata1 = {REG_WIDTH{1'b0}};
    end else if ((bus.re1 == ReadEnable) && (bus.we == WriteEnable) &&
                 (bus.waddr == bus.raddr1)) begin
      rdata1 = bus.wdata;
    end else if (bus.re1 == ReadEnable) begin
      rdata1 = regs[bus.raddr1];
    end else begin
      rdata1 = {REG_WIDTH{1'b0}};
    end
  end

  // Read port 2: same priority as port 1, bypass evaluated independently
  always_comb begin
    rdata2 = {REG_WIDTH{1'b0}};
    if (rst == RstEnable) begin
      rdata2 = {REG_WIDTH{1'b0}};
    end else if (bus.raddr2 == NOPRegAddr) begin
      rdata2 = {REG_WIDTH{1'b0}};
    end else if ((bus.re2 == ReadEnable) && (bus.we == WriteEnable) &&
                 (bus.waddr == bus.raddr2)) begin
      rdata2 = bus.wdata;
    end else if (bus.re2 == ReadEnable) begin
      rdata2 = regs[bus.raddr2];
    end else begin
      rdata2 = {REG_WIDTH{1'b0}};
    end
  end

  assign bus.rdata1 = rdata1;
  assign bus.rdata2 = rdata2;

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .whilo (bus.whilo),
    .hi_i  (bus.hi_i),
    .lo_i  (bus.lo_i),
    .hi_o  (bus.hi_o),
    .lo_o  (bus.lo_o)
  );

endmodule : regfile_hilo

// File: tb/tb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// tb_regfile_hilo
// Directed and randomized checks of regfile_hilo against a behavioural model
// (plain arrays for GPRs and HI/LO, read rules evaluated from scratch).
// ---------------------------------------------------------------------------
module tb_regfile_hilo;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  regfile_hilo_if bus ();

  regfile_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
    if (rst)                                  return 32'h0;
    if (ra == 5'd0)                           return 32'h0;
    if (re && bus.we && (bus.waddr == ra))    return bus.wdata;
    if (re)                                   return m_gpr[ra];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2,
                       input logic wh, input logic [31:0] hv, input logic [31:0] lv);
    bus.we = we;  bus.waddr = wa;  bus.wdata = wd;
    bus.re1 = r1; bus.raddr1 = a1;
    bus.re2 = r2; bus.raddr2 = a2;
    bus.whilo = wh; bus.hi_i = hv; bus.lo_i = lv;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata1"}, bus.rdata1, exp_read(bus.re1, bus.raddr1));
    check({tag, ".rdata2"}, bus.rdata2, exp_read(bus.re2, bus.raddr2));
    check({tag, ".hi_o"},   bus.hi_o,   m_hi);
    check({tag, ".lo_o"},   bus.lo_o,   m_lo);
  endtask

  // advance over one rising edge, committing the expected write effects
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.we && (bus.waddr != 5'd0)) m_gpr[bus.waddr] = bus.wdata;
      if (bus.whilo) begin
        m_hi = bus.hi_i;
        m_lo = bus.lo_i;
      end
    end
    #1;
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hCAFE_F00D, 1'b1, 5'd5, 1'b1, 5'd31, 1'b1, 32'h1111_1111, 32'h2222_2222);

    // 1. reset held for two edges: write attempts must not land
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold.rdata1", bus.rdata1, 32'h0);
    check("rst_hold.hi_o",   bus.hi_o,   32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("rst1.rdata1", bus.rdata1, 32'h0);
    check("rst1.rdata2", bus.rdata2, 32'h0);
    check("rst1.hi_o",   bus.hi_o,   32'h0);
    check("rst1.lo_o",   bus.lo_o,   32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst1.no_write_r4", bus.rdata1, 32'h0);
    tick();

    // 2. plain write then read; disabled read gives zero
    drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); check_all("wr3");
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd3.rdata1", bus.rdata1, 32'h1234_5678);
    check("rd3_re0.rdata2", bus.rdata2, 32'h0);
    tick();

    // 3. same-cycle write-through on both ports
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("byp7.rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check("byp7.rdata2", bus.rdata2, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("hold7.rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check("hold7.rdata2", bus.rdata2, 32'h1234_5678);
    tick();

    // 4. write to register 0 is discarded, including the bypass path
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("r0_byp.rdata1", bus.rdata1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("r0_after.rdata1", bus.rdata1, 32'h0);
    check("r0_after.rdata2", bus.rdata2, 32'h0);
    tick();

    // 5. HI/LO: unchanged in the write cycle, updated the cycle after
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hA5A5_0000, 32'h0000_5A5A);
    @(negedge clk);
    check("hilo_wr.hi_o", bus.hi_o, 32'h0);
    check("hilo_wr.lo_o", bus.lo_o, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("hilo_new.hi_o", bus.hi_o, 32'hA5A5_0000);
    check("hilo_new.lo_o", bus.lo_o, 32'h0000_5A5A);
    tick();

    // 6. load GPR9/HI, then pulse reset between edges
    drive(1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h0000_0001, 32'h0000_0002);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0);
    #1;
    check("pre_rst.rdata1", bus.rdata1, 32'h0000_0055);
    check("pre_rst.hi_o",   bus.hi_o,   32'h0000_0001);
    rst = 1'b1;
    #1;
    check("mid_rst.rdata1", bus.rdata1, 32'h0);
    check("mid_rst.rdata2", bus.rdata2, 32'h0);
    check("mid_rst.hi_o",   bus.hi_o,   32'h0);
    check("mid_rst.lo_o",   bus.lo_o,   32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst.rdata1", bus.rdata1, 32'h0);
    check("post_rst.rdata2", bus.rdata2, 32'h0);
    check("post_rst.hi_o",   bus.hi_o,   32'h0);
    tick();
    drive(1'b1, 5'd9, 32'h0BAD_CAFE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_rst_wr.rdata1", bus.rdata1, 32'h0BAD_CAFE);
    tick();

    // randomized traffic, read addresses biased toward the write address
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) == 0), $urandom, $urandom);
      @(negedge clk);
      check_all("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_hilo

// File: doc/regfile_hilo.md
Name: regfile_hilo

Overview:
- Register file that answers the decode stage's read requests and takes write-back from the WB stage.
- Holds the 32 general-purpose registers and the separate HI/LO pair.
- Two combinational read ports with same-cycle write-through bypass; one synchronous GPR write port; one synchronous HI/LO write port.
- Sits between MEM/WB and ID; forwarding of EX/MEM results remains the decode stage's job.

Parameters:
- REG_NUM, 32, number of general-purpose registers.
- REG_WIDTH, 32, data width of each GPR and of HI/LO.
- ADDR_WIDTH, 5, GPR address width; 2**ADDR_WIDTH equals REG_NUM.

Ports:
- clk  in  1  single clock, rising-edge active.
- rst  in  1  reset, asynchronous and active-high.
- we  in  1  GPR write enable from WB.
- waddr  in  ADDR_WIDTH  GPR write address.
- wdata  in  REG_WIDTH  GPR write data.
- re1  in  1  read-port-1 enable from decode.
- raddr1  in  ADDR_WIDTH  read-port-1 address.
- rdata1  out  REG_WIDTH  read-port-1 data.
- re2  in  1  read-port-2 enable from decode.
- raddr2  in  ADDR_WIDTH  read-port-2 address.
- rdata2  out  REG_WIDTH  read-port-2 data.
- whilo  in  1  HI/LO write enable from WB.
- hi_i  in  REG_WIDTH  HI write data.
- lo_i  in  REG_WIDTH  LO write data.
- hi_o  out  REG_WIDTH  current HI value.
- lo_o  out  REG_WIDTH  current LO value.

Behaviour:
- Reset (rst=1, asynchronous):
  - All REG_NUM GPRs clear to 0; HI and LO clear to 0.
  - rdata1, rdata2, hi_o, lo_o read 0 for as long as rst is high.
  - Reset overrides a coincident we or whilo; no write lands.
- GPR write: on rising clk with rst=0 and we=1, GPR[waddr] <= wdata. A write to address 0 is discarded; GPR0 always reads 0.
- Read port n (combinational, zero latency), priority order:
  1. rst=1 -> 0.
  2. raddrn=0 -> 0, regardless of a bypass match.
  3. ren=1 and we=1 and waddr=raddrn -> wdata (write-through bypass).
  4. ren=1 -> GPR[raddrn].
  5. ren=0 -> 0.
- Both read ports may address the same register; both bypass independently.
- HI/LO write: on rising clk with rst=0 and whilo=1, HI <= hi_i and LO <= lo_i together. There is no partial write; MTHI/MTLO callers supply the unchanged half.
- hi_o/lo_o show registered HI/LO with one-cycle write latency and no bypass; EX performs HI/LO forwarding.
- Reset mid-operation: an asynchronous assert wipes state immediately. After deassert, the first rising edge with we=1 writes normally.
- There is no state machine. State is GPR array plus HI/LO only; all outputs are combinational over that state.

Decomposition:
- Shared defines package holds:
  - RegBus, RegAddrBus, RegNum, RegNumLog2.
  - ZeroWord, NOPRegAddr.
  - WriteEnable/WriteDisable, ReadEnable/ReadDisable.
  - RstEnable (1'b1).
- One natural sub-module: hilo_reg (HI/LO pair with whilo). The GPR array and read muxes stay in the top.

Test Plan:
1. Assert rst for 2 cycles, then re1=re2=1, raddr1=5, raddr2=31 -> rdata1=rdata2=0, hi_o=lo_o=0.
2. Write we=1, waddr=3, wdata=32'h1234_5678; next cycle read raddr1=3 -> rdata1=32'h1234_5678. With re1=0 -> 0.
3. Same cycle we=1, waddr=7, wdata=32'hDEAD_BEEF, raddr1=raddr2=7, re1=re2=1 -> both read 32'hDEAD_BEEF before the edge; GPR7 holds it after.
4. we=1, waddr=0, wdata=32'hFFFF_FFFF with raddr1=0 -> rdata1=0 in that cycle and every later cycle.
5. whilo=1, hi_i=32'hA5A5_0000, lo_i=32'h0000_5A5A -> hi_o/lo_o unchanged in that cycle, equal to the new values the cycle after.
6. Load GPR9=32'h55 and HI=32'h1, then pulse rst mid-cycle (not at an edge) -> rdata/hi_o/lo_o drop to 0 immediately and stay 0 after rst deasserts.
